fifo_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one valid/ready FIFO input port between `NUM_IN` requesters. It sits directly in front of a `fifo_wrapper` instance. It grants one requester at a time, passes that requester's beats through, and tags each beat with its source index. A grant is held for at most `MAX_BURST` beats, which bounds latency for the other requesters.

---
 rtl/fifo_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter
//
// Round-robin arbiter that multiplexes NUM_IN valid/ready requesters onto a
// single valid/ready FIFO input port. One requester owns the port at a time.
// Ownership ends after MAX_BURST beats, or as soon as the owner drops valid.
// The next search then starts just past the released owner, so that owner has
// the lowest priority in the next arbitration.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   per-requester valid                   [NUM_IN]
//   in_ready   per-requester ready, one-hot or zero  [NUM_IN]
//   in_data    requester i at [i*WIDTH +: WIDTH]     [NUM_IN*WIDTH]
//   out_valid  beat valid towards the FIFO
//   out_ready  FIFO input ready
//   out_data   granted requester's data (0 while idle)
//   out_src    granted requester index (0 while idle)
//   busy       high while a requester holds the grant
module fifo_rr_arbiter #(
    parameter int NUM_IN    = 4,
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN-1:0]         in_valid,
    output logic [NUM_IN-1:0]         in_ready,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_IN)-1:0] out_src,
    output logic                      busy
);

    localparam int SW  = $clog2(NUM_IN);
    localparam int SW1 = SW + 1;
    localparam int CW  = $clog2(MAX_BURST + 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [SW-1:0]  LAST_IDX  = SW'(NUM_IN - 1);
    localparam logic [SW1-1:0] NUM_IN_W  = SW1'(NUM_IN);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);

    logic [0:0]    state;
    logic [SW-1:0] grant;
    logic [SW-1:0] rr_ptr;
    logic [CW-1:0] burst_cnt;

    // Unpack the flat data bus so the grant can index it directly.
    logic [WIDTH-1:0] data_arr [NUM_IN];

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
            assign data_arr[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Circular scan starting at rr_ptr. The candidate index is reduced
    // modulo NUM_IN, not 2**SW, so non-power-of-2 requester counts never
    // produce an out-of-range index.
    logic           sel_found;
    logic [SW-1:0]  sel;
    logic [SW1-1:0] cand;

    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        cand      = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand = {1'b0, rr_ptr} + SW1'(k);
            if (cand >= NUM_IN_W) begin
                cand = cand - NUM_IN_W;
            end
            if (!sel_found && in_valid[cand[SW-1:0]]) begin
                sel_found = 1'b1;
                sel       = cand[SW-1:0];
            end
        end
    end

    logic [SW-1:0] next_ptr;
    assign next_ptr = (grant == LAST_IDX) ? '0 : grant + 1'b1;

    // Pass-through paths. out_valid depends only on in_valid and the grant,
    // so there is no combinational path from out_ready back to out_valid.
    assign busy      = (state == LOCKED);
    assign out_valid = busy & in_valid[grant];
    assign out_data  = busy ? data_arr[grant] : '0;
    assign out_src   = busy ? grant : '0;

    always_comb begin
        in_ready = '0;
        if (busy) begin
            in_ready[grant] = out_ready;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else if (state == IDLE) begin
            if (sel_found) begin
                grant     <= sel;
                burst_cnt <= '0;
                state     <= LOCKED;
            end
        end else begin
            if (!in_valid[grant]) begin
                // Owner has no more data: give the port up at once.
                state  <= IDLE;
                rr_ptr <= next_ptr;
            end else if (out_ready) begin
                burst_cnt <= burst_cnt + 1'b1;
                // The last beat of a full burst and the release share an edge.
                if (burst_cnt == LAST_BEAT) begin
                    state  <= IDLE;
                    rr_ptr <= next_ptr;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Testbench for fifo_rr_arbiter: table vectors, directed corner sequences
// and a randomized run against a behavioural model with a FIFO scoreboard.
module tb_fifo_rr_arbiter;

    localparam int NUM_IN     = 4;
    localparam int WIDTH      = 4;
    localparam int MAX_BURST  = 4;
    localparam int SW         = 2;
    localparam int FIFO_DEPTH = 16;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SW-1:0]           out_src;
    logic                    busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(
        .NUM_IN   (NUM_IN),
        .WIDTH    (WIDTH),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_src  (out_src),
        .busy     (busy)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Behavioural model: owner == -1 means nobody holds the port.
    int m_owner;
    int m_ptr;
    int m_beats;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
    endfunction

    // Expected outputs for the current cycle, packed as
    // {out_valid, in_ready, out_src, out_data, busy}.
    function automatic void model_check(input string tag);
        logic             e_valid = 1'b0;
        logic [NUM_IN-1:0] e_ready = '0;
        logic [SW-1:0]    e_src   = '0;
        logic [WIDTH-1:0] e_data  = '0;
        logic             e_busy  = 1'b0;
        if (m_owner >= 0) begin
            e_valid          = in_valid[m_owner];
            e_ready[m_owner] = out_ready;
            e_src            = m_owner[SW-1:0];
            e_data           = in_data[m_owner*WIDTH +: WIDTH];
            e_busy           = 1'b1;
        end
        chk(tag, {20'd0, out_valid, in_ready, out_src, out_data, busy},
                 {20'd0, e_valid, e_ready, e_src, e_data, e_busy});
    endfunction

    // Advance the model by one clock using the inputs that were applied
    // during the cycle that just ended.
    function automatic void model_step();
        if (m_owner < 0) begin
            for (int k = 0; k < NUM_IN; k++) begin
                int c;
                c = (m_ptr + k) % NUM_IN;
                if (in_valid[c]) begin
                    m_owner = c;
                    m_beats = 0;
                    break;
                end
            end
        end else if (!in_valid[m_owner]) begin
            m_ptr   = (m_owner + 1) % NUM_IN;
            m_owner = -1;
        end else if (out_ready) begin
            m_beats++;
            if (m_beats == MAX_BURST) begin
                m_ptr   = (m_owner + 1) % NUM_IN;
                m_owner = -1;
            end
        end
    endfunction

    task automatic cyc_post();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [NUM_IN-1:0]       iv;
        logic [NUM_IN*WIDTH-1:0] id;
        logic                    ordy;
        logic                    ev;
        logic [NUM_IN-1:0]       er;
        logic [SW-1:0]           es;
        logic [WIDTH-1:0]        ed;
        logic                    eb;
    } vec_t;

    vec_t vecs [12];

    int           cnt_left [NUM_IN];
    int           seq      [NUM_IN];
    int           exp_next [NUM_IN];
    int           q [$];
    bit           stalled;
    bit           xfer;
    logic [NUM_IN-1:0] ir;
    int           ent;
    int           beats;
    int           seq2;
    int           first_idle;
    int           grant3;
    bit           had_busy;
    bit           done3;
    int           in_q;

    initial begin
        // Rows: inputs, then expected {valid, ready, src, data, busy}.
        vecs[0]  = '{4'b0001, 16'h000A, 1'b1, 1'b0, 4'b0000, 2'd0, 4'h0, 1'b0};
        vecs[1]  = '{4'b0001, 16'h000A, 1'b1, 1'b1, 4'b0001, 2'd0, 4'hA, 1'b1};
        vecs[2]  = '{4'b0001, 16'h000B, 1'b1, 1'b1, 4'b0001, 2'd0, 4'hB, 1'b1};
        vecs[3]  = '{4'b0001, 16'h000C, 1'b1, 1'b1, 4'b0001, 2'd0, 4'hC, 1'b1};
        vecs[4]  = '{4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0001, 2'd0, 4'h0, 1'b1};
        vecs[5]  = '{4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 2'd0, 4'h0, 1'b0};
        vecs[6]  = '{4'b1001, 16'h5001, 1'b1, 1'b0, 4'b0000, 2'd0, 4'h0, 1'b0};
        vecs[7]  = '{4'b1001, 16'h5001, 1'b0, 1'b1, 4'b0000, 2'd3, 4'h5, 1'b1};
        vecs[8]  = '{4'b1001, 16'h5001, 1'b1, 1'b1, 4'b1000, 2'd3, 4'h5, 1'b1};
        vecs[9]  = '{4'b0001, 16'h0001, 1'b1, 1'b0, 4'b1000, 2'd3, 4'h0, 1'b1};
        vecs[10] = '{4'b0001, 16'h0001, 1'b1, 1'b0, 4'b0000, 2'd0, 4'h0, 1'b0};
        vecs[11] = '{4'b0001, 16'h0001, 1'b1, 1'b1, 4'b0001, 2'd0, 4'h1, 1'b1};

        // Reset values
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_outputs", {20'd0, out_valid, in_ready, out_src, out_data, busy}, 32'd0);
        $display("reset: valid=%b ready=%b src=%0d data=%h busy=%b",
                 out_valid, in_ready, out_src, out_data, busy);
        reset = 1'b0;
        model_reset();

        // Table vectors: single-requester burst with drop, rr_ptr advance,
        // backpressure and wrap of the pointer.
        for (int v = 0; v < 12; v++) begin
            in_valid  = vecs[v].iv;
            in_data   = vecs[v].id;
            out_ready = vecs[v].ordy;
            #1;
            chk($sformatf("vec%0d", v),
                {20'd0, out_valid, in_ready, out_src, out_data, busy},
                {20'd0, vecs[v].ev, vecs[v].er, vecs[v].es, vecs[v].ed, vecs[v].eb});
            $display("vec %0d: iv=%b ordy=%b -> valid=%b ready=%b src=%0d data=%h busy=%b",
                     v, vecs[v].iv, vecs[v].ordy, out_valid, in_ready, out_src, out_data, busy);
            cyc_post();
        end

        // All requesters streaming: 4 beats per grant, one idle cycle between.
        do_reset();
        for (int c = 0; c < 25; c++) begin
            in_valid  = 4'b1111;
            in_data   = 16'h4321;
            out_ready = 1'b1;
            #1;
            model_check($sformatf("rot_model%0d", c));
            if (c % 5 == 0) begin
                chk($sformatf("rot%0d", c), {busy, out_valid, out_src, out_data}, 8'h00);
            end else begin
                chk($sformatf("rot%0d", c), {busy, out_valid, out_src, out_data},
                    {2'b11, 2'((c / 5) % 4), 4'((c / 5) % 4 + 1)});
            end
            $display("rot cycle %0d: busy=%b src=%0d data=%h", c, busy, out_src, out_data);
            cyc_post();
        end

        // Backpressure in the middle of requester 2's burst.
        do_reset();
        seq2  = 0;
        beats = 0;
        for (int c = 0; c < 11; c++) begin
            in_valid  = 4'b0100;
            in_data   = '0;
            in_data[2*WIDTH +: WIDTH] = WIDTH'(seq2);
            out_ready = !(c >= 3 && c < 8);
            #1;
            model_check($sformatf("bp_model%0d", c));
            if (c >= 3 && c < 8) begin
                chk($sformatf("bp_ready%0d", c), 32'(in_ready), 32'd0);
                chk($sformatf("bp_hold%0d", c), 32'(out_data), 32'd2);
            end
            if (c == 10) chk("bp_released", 32'(busy), 32'd0);
            xfer = out_valid && out_ready && in_ready[2];
            if (xfer) begin
                chk($sformatf("bp_beat%0d", beats), 32'(out_data), 32'(beats));
                $display("bp beat %0d: data=%h src=%0d", beats, out_data, out_src);
            end
            cyc_post();
            if (xfer) begin
                beats++;
                seq2++;
            end
        end
        chk("bp_total_beats", 32'(beats), 32'(MAX_BURST));

        // Starvation: requester 0 streams, requester 3 asks once.
        do_reset();
        first_idle = -1;
        grant3     = -1;
        had_busy   = 1'b0;
        done3      = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_valid  = {(c >= 2) && !done3, 3'b001};
            in_data   = 16'h9001;
            out_ready = 1'b1;
            #1;
            model_check($sformatf("starve_model%0d", c));
            if (busy) had_busy = 1'b1;
            if (had_busy && !busy && first_idle < 0) first_idle = c;
            xfer = out_valid && (out_src == 2'd3);
            if (xfer && grant3 < 0) grant3 = c;
            cyc_post();
            if (xfer) done3 = 1'b1;
        end
        $display("starve: req0 released at cycle %0d, req3 served at cycle %0d", first_idle, grant3);
        chk("starve_latency",
            32'(grant3 >= 0 && first_idle >= 0 && grant3 > first_idle
                && (grant3 - first_idle) <= MAX_BURST + 1), 32'd1);

        // Reset in the middle of requester 1's burst.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            in_valid  = 4'b0010;
            in_data   = 16'h0070;
            out_ready = 1'b1;
            #1;
            model_check($sformatf("rst_model%0d", c));
            cyc_post();
        end
        #1;
        chk("rst_pre_busy", {busy, out_src}, {1'b1, 2'd1});
        reset = 1'b1;
        #1;
        chk("rst_async_outputs", {20'd0, out_valid, in_ready, out_src, out_data, busy}, 32'd0);
        $display("mid-burst reset: valid=%b ready=%b src=%0d busy=%b", out_valid, in_ready, out_src, busy);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            in_valid  = 4'b1111;
            in_data   = 16'h4321;
            out_ready = 1'b1;
            #1;
            model_check($sformatf("rst_after_model%0d", c));
            if (c == 1) chk("rst_first_grant", {busy, out_valid, out_src}, {2'b11, 2'd0});
            cyc_post();
        end

        // Randomized run feeding a 16-deep FIFO whose consumer waits for full.
        do_reset();
        for (int i = 0; i < NUM_IN; i++) begin
            cnt_left[i] = 0;
            seq[i]      = 0;
            exp_next[i] = 0;
        end
        stalled = 1'b1;
        for (int c = 0; c < 600; c++) begin
            in_data = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (cnt_left[i] == 0 && $urandom_range(3) == 0) cnt_left[i] = $urandom_range(7, 1);
                in_valid[i] = (cnt_left[i] != 0);
                in_data[i*WIDTH +: WIDTH] = WIDTH'(seq[i]);
            end
            out_ready = (q.size() < FIFO_DEPTH);
            #1;
            model_check($sformatf("rand_model%0d", c));
            xfer = out_valid && out_ready;
            ent  = int'(out_src) * 16 + int'(out_data);
            ir   = in_ready;
            @(posedge clk);
            model_step();
            for (int i = 0; i < NUM_IN; i++) begin
                if (ir[i] && in_valid[i]) begin
                    seq[i]++;
                    cnt_left[i]--;
                end
            end
            if (xfer) q.push_back(ent);
            if (q.size() == FIFO_DEPTH) stalled = 1'b0;
            if (!stalled && q.size() > 0 && $urandom_range(1) == 0) begin
                ent = q.pop_front();
                chk($sformatf("sb_src%0d_beat%0d", ent / 16, exp_next[ent / 16]),
                    32'(ent % 16), 32'(exp_next[ent / 16] % 16));
                $display("pop: src=%0d data=%h", ent / 16, ent % 16);
                exp_next[ent / 16]++;
            end
            #1;
        end
        // Every accepted beat is either consumed or still queued.
        for (int i = 0; i < NUM_IN; i++) begin
            in_q = 0;
            foreach (q[j]) if (q[j] / 16 == i) in_q++;
            chk($sformatf("sb_count_src%0d", i), 32'(exp_next[i] + in_q), 32'(seq[i]));
            $display("src %0d: accepted=%0d consumed=%0d queued=%0d", i, seq[i], exp_next[i], in_q);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
